// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle control FSM
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_BEQ  = 4'd10,
    ALU_BNE  = 4'd11,
    ALU_BLT  = 4'd12,
    ALU_BGE  = 4'd13,
    ALU_BLTU = 4'd14,
    ALU_BGEU = 4'd15
  } alu_op_e;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] TC_NONE     = 2'd0;
  localparam logic [1:0] TC_ILLEGAL  = 2'd1;
  localparam logic [1:0] TC_FETCH_TO = 2'd2;
  localparam logic [1:0] TC_DATA_TO  = 2'd3;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL, OP_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_alu_dec.sv
// rtl/ctrl_alu_dec.sv - combinational opcode/funct to ALU operation decode
module ctrl_alu_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [3:0] funct,
  output logic [3:0] alu_op
);

  alu_op_e op;

  // funct[3] selects SUB only for R-type; shifts honour it for both R and I forms
  always_comb begin
    op = ALU_ADD;
    case (opcode)
      OP_R, OP_IMM: begin
        case (funct[2:0])
          3'b000:  op = (opcode == OP_R && funct[3]) ? ALU_SUB : ALU_ADD;
          3'b001:  op = ALU_SLL;
          3'b010:  op = ALU_SLT;
          3'b011:  op = ALU_SLTU;
          3'b100:  op = ALU_XOR;
          3'b101:  op = funct[3] ? ALU_SRA : ALU_SRL;
          3'b110:  op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
      OP_BRANCH: begin
        case (funct[2:0])
          3'b001:  op = ALU_BNE;
          3'b100:  op = ALU_BLT;
          3'b101:  op = ALU_BGE;
          3'b110:  op = ALU_BLTU;
          3'b111:  op = ALU_BGEU;
          default: op = ALU_BEQ;
        endcase
      end
      default: op = ALU_ADD;
    endcase
  end

  assign alu_op = op;

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I-subset control FSM
// Optional MULTICYCLE_CTRL_PERF_EN adds cycle_cnt / instret counters.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [3:0]  funct,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        mem_is_data,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [1:0]  trap_cause
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret
`endif
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_is_data_q, mem_is_data_d;
  logic        pc_we_q, pc_we_d;
  logic [1:0]  pc_sel_q, pc_sel_d;
  logic        alu_src_a_q, alu_src_a_d;
  logic        alu_src_b_q, alu_src_b_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic        rf_we_q, rf_we_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic        trap_q, trap_d;
  logic [1:0]  trap_cause_q, trap_cause_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]  dec_alu_op;
  logic        mem_done, timeout, fetch_done, br_take;

  ctrl_alu_dec u_alu_dec (
    .opcode (opcode),
    .funct  (funct),
    .alu_op (dec_alu_op)
  );

  assign mem_done   = mem_req_q & mem_ready;
  assign timeout    = (MEM_TIMEOUT != 0) && mem_req_q && !mem_ready && (wait_cnt_q == LIMIT);
  assign fetch_done = (state_q == ST_FETCH) && mem_done;
  assign br_take    = (state_q == ST_EXEC) && (opcode == OP_BRANCH) && br_taken;

  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_done) begin
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d      = ST_TRAP;
          trap_cause_d = TC_FETCH_TO;
        end
      end
      ST_DECODE: begin
        if (is_legal(opcode)) begin
          state_d = ST_EXEC;
        end else begin
          state_d      = ST_TRAP;
          trap_cause_d = TC_ILLEGAL;
        end
      end
      ST_EXEC: begin
        case (opcode)
          OP_R, OP_IMM:      state_d = ST_WB;
          OP_LOAD, OP_STORE: state_d = ST_MEM;
          default:           state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_done) begin
          state_d = (opcode == OP_STORE) ? ST_FETCH : ST_WB;
        end else if (timeout) begin
          state_d      = ST_TRAP;
          trap_cause_d = TC_DATA_TO;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      default: state_d = ST_TRAP;
    endcase
  end

  // Outputs are registered from the next state so they are valid for the whole state cycle
  always_comb begin
    mem_req_d     = (state_d == ST_FETCH) || (state_d == ST_MEM);
    mem_is_data_d = (state_d == ST_MEM);
    mem_we_d      = (state_d == ST_MEM) && (opcode == OP_STORE);
    pc_we_d       = 1'b0;
    pc_sel_d      = PC_PLUS4;
    alu_src_a_d   = 1'b0;
    alu_src_b_d   = 1'b0;
    alu_op_d      = 4'd0;
    rf_we_d       = 1'b0;
    wb_sel_d      = WB_ALU;
    trap_d        = (state_d == ST_TRAP);
    if (state_d == ST_EXEC) begin
      alu_op_d = dec_alu_op;
      case (opcode)
        OP_IMM, OP_LOAD, OP_STORE: alu_src_b_d = 1'b1;
        OP_JAL: begin
          alu_src_a_d = 1'b1;
          alu_src_b_d = 1'b1;
          rf_we_d     = 1'b1;
          wb_sel_d    = WB_PC4;
          pc_we_d     = 1'b1;
          pc_sel_d    = PC_IMM;
        end
        OP_JALR: begin
          alu_src_b_d = 1'b1;
          rf_we_d     = 1'b1;
          wb_sel_d    = WB_PC4;
          pc_we_d     = 1'b1;
          pc_sel_d    = PC_JALR;
        end
        OP_LUI: begin
          rf_we_d  = 1'b1;
          wb_sel_d = WB_IMM;
        end
        default: ;
      endcase
    end
    if (state_d == ST_WB) begin
      rf_we_d  = 1'b1;
      wb_sel_d = (opcode == OP_LOAD) ? WB_MEM : WB_ALU;
    end
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (mem_req_q && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d, instret_q, instret_d;

  always_comb begin
    cycle_cnt_d = (state_q == ST_TRAP) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
    instret_d   = instret_q;
    if (state_d == ST_FETCH &&
        (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB)) begin
      instret_d = instret_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instret   = instret_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_is_data_q <= 1'b0;
      pc_we_q       <= 1'b0;
      pc_sel_q      <= PC_PLUS4;
      alu_src_a_q   <= 1'b0;
      alu_src_b_q   <= 1'b0;
      alu_op_q      <= 4'd0;
      rf_we_q       <= 1'b0;
      wb_sel_q      <= WB_ALU;
      trap_q        <= 1'b0;
      trap_cause_q  <= TC_NONE;
      wait_cnt_q    <= '0;
`ifdef MULTICYCLE_CTRL_PERF_EN
      cycle_cnt_q   <= 32'd0;
      instret_q     <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_is_data_q <= mem_is_data_d;
      pc_we_q       <= pc_we_d;
      pc_sel_q      <= pc_sel_d;
      alu_src_a_q   <= alu_src_a_d;
      alu_src_b_q   <= alu_src_b_d;
      alu_op_q      <= alu_op_d;
      rf_we_q       <= rf_we_d;
      wb_sel_q      <= wb_sel_d;
      trap_q        <= trap_d;
      trap_cause_q  <= trap_cause_d;
      wait_cnt_q    <= wait_cnt_d;
`ifdef MULTICYCLE_CTRL_PERF_EN
      cycle_cnt_q   <= cycle_cnt_d;
      instret_q     <= instret_d;
`endif
    end
  end

  // Fetch handshake and branch decision depend on this cycle's inputs
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_is_data = mem_is_data_q;
  assign ir_we       = fetch_done;
  assign pc_we       = pc_we_q | fetch_done | br_take;
  assign pc_sel      = br_take ? PC_IMM : pc_sel_q;
  assign alu_src_a   = alu_src_a_q;
  assign alu_src_b   = alu_src_b_q;
  assign alu_op      = alu_op_q;
  assign rf_we       = rf_we_q;
  assign wb_sel      = wb_sel_q;
  assign trap        = trap_q;
  assign trap_cause  = trap_cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [3:0]  funct = 4'd0;
  logic        br_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_is_data, ir_we, pc_we;
  logic [1:0]  pc_sel, wb_sel, trap_cause;
  logic        alu_src_a, alu_src_b, rf_we, trap;
  logic [3:0]  alu_op;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret;
`endif

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .funct       (funct),
    .br_taken    (br_taken),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_ready   (mem_ready),
    .mem_is_data (mem_is_data),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .rf_we       (rf_we),
    .wb_sel      (wb_sel),
    .trap        (trap),
    .trap_cause  (trap_cause)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret     (instret)
`endif
  );

  always #5 clk = ~clk;

  // {mem_req, mem_is_data, mem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel, trap, trap_cause}
  logic [12:0] obs;
  assign obs = {mem_req, mem_is_data, mem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel, trap, trap_cause};

  localparam logic [12:0] F_RDY    = 13'b1_0_0_1_1_00_0_00_0_00;
  localparam logic [12:0] IDLE     = 13'b0_0_0_0_0_00_0_00_0_00;
  localparam logic [12:0] WB_ALU_E = 13'b0_0_0_0_0_00_1_00_0_00;
  localparam logic [12:0] WB_MEM_E = 13'b0_0_0_0_0_00_1_01_0_00;
  localparam logic [12:0] MEM_RD   = 13'b1_1_0_0_0_00_0_00_0_00;
  localparam logic [12:0] MEM_WR   = 13'b1_1_1_0_0_00_0_00_0_00;
  localparam logic [12:0] MEM_F    = 13'b1_0_0_0_0_00_0_00_0_00;
  localparam logic [12:0] BR_TK    = 13'b0_0_0_0_1_01_0_00_0_00;
  localparam logic [12:0] JAL_E    = 13'b0_0_0_0_1_01_1_10_0_00;
  localparam logic [12:0] JALR_E   = 13'b0_0_0_0_1_10_1_10_0_00;
  localparam logic [12:0] LUI_E    = 13'b0_0_0_0_0_00_1_11_0_00;
  localparam logic [12:0] TRAP_ILL = 13'b0_0_0_0_0_00_0_00_1_01;
  localparam logic [12:0] TRAP_FTO = 13'b0_0_0_0_0_00_0_00_1_10;
  localparam logic [12:0] TRAP_DTO = 13'b0_0_0_0_0_00_0_00_1_11;

  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] nxt_op = 7'd0;
  logic [3:0] nxt_fn = 4'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive inputs just after the rising edge, sample outputs on the falling edge
  task automatic cyc(input string tag, input logic rdy, input logic brt, input logic [12:0] exp);
    @(posedge clk);
    #1;
    opcode    = nxt_op;
    funct     = nxt_fn;
    mem_ready = rdy;
    br_taken  = brt;
    @(negedge clk);
    check_eq(tag, {19'd0, obs}, {19'd0, exp});
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_eq(tag, {19'd0, obs}, 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    check_eq({tag, "_cyc"}, cycle_cnt, 32'd0);
    check_eq({tag, "_ret"}, instret, 32'd0);
`endif
    mem_ready = 1'b0;
    br_taken  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_alu(input string tag, input logic [6:0] op, input logic [3:0] fn,
                         input logic [3:0] exp_op, input logic exp_srcb);
    nxt_op = op;
    nxt_fn = fn;
    cyc({tag, "_fetch"}, 1'b1, 1'b0, F_RDY);
    cyc({tag, "_decode"}, 1'b1, 1'b0, IDLE);
    cyc({tag, "_exec"}, 1'b1, 1'b0, IDLE);
    check_eq({tag, "_aluop"}, {28'd0, alu_op}, {28'd0, exp_op});
    check_eq({tag, "_srcb"}, {31'd0, alu_src_b}, {31'd0, exp_srcb});
    cyc({tag, "_wb"}, 1'b1, 1'b0, WB_ALU_E);
  endtask

  logic [6:0]  j_ops [3];
  logic [12:0] j_exp [3];

  initial begin
    j_ops = '{7'h6F, 7'h67, 7'h37};
    j_exp = '{JAL_E, JALR_E, LUI_E};
    #1;
    do_reset("rst_init");

    run_alu("t1_addi", 7'h13, 4'b0000, 4'd0, 1'b1);

    nxt_op = 7'h03;
    nxt_fn = 4'b0010;
    cyc("t2_fetch", 1'b1, 1'b0, F_RDY);
    cyc("t2_decode", 1'b1, 1'b0, IDLE);
    cyc("t2_exec", 1'b1, 1'b0, IDLE);
    for (int i = 0; i < 3; i++) cyc("t2_mem_wait", 1'b0, 1'b0, MEM_RD);
    cyc("t2_mem_done", 1'b1, 1'b0, MEM_RD);
    cyc("t2_wb", 1'b0, 1'b0, WB_MEM_E);

    nxt_op = 7'h63;
    nxt_fn = 4'b0000;
    cyc("t3_fetch", 1'b1, 1'b0, F_RDY);
`ifdef MULTICYCLE_CTRL_PERF_EN
    check_eq("perf_instret", instret, 32'd2);
`endif
    cyc("t3_decode", 1'b1, 1'b0, IDLE);
    cyc("t3_exec_taken", 1'b1, 1'b1, BR_TK);
    check_eq("t3_beq_op", {28'd0, alu_op}, 32'd10);
    nxt_fn = 4'b0101;
    cyc("t3_fetch2", 1'b1, 1'b0, F_RDY);
    cyc("t3_decode2", 1'b1, 1'b0, IDLE);
    cyc("t3_exec_not", 1'b1, 1'b0, IDLE);
    check_eq("t3_bge_op", {28'd0, alu_op}, 32'd13);

    for (int i = 0; i < 3; i++) begin
      nxt_op = j_ops[i];
      nxt_fn = 4'b0000;
      cyc("tj_fetch", 1'b1, 1'b0, F_RDY);
      cyc("tj_decode", 1'b1, 1'b0, IDLE);
      cyc("tj_exec", 1'b1, 1'b0, j_exp[i]);
    end

    run_alu("tr_sub", 7'h33, 4'b1000, 4'd1, 1'b0);
    run_alu("ti_addi_f3", 7'h13, 4'b1000, 4'd0, 1'b1);
    run_alu("ti_srai", 7'h13, 4'b1101, 4'd7, 1'b1);
    run_alu("tr_srl", 7'h33, 4'b0101, 4'd6, 1'b0);

    nxt_op = 7'h7F;
    nxt_fn = 4'b0000;
    cyc("t4_fetch", 1'b1, 1'b0, F_RDY);
    cyc("t4_decode", 1'b1, 1'b0, IDLE);
    for (int i = 0; i < 20; i++) cyc("t4_trap", 1'b1, 1'b1, TRAP_ILL);
    do_reset("t4_rst");

    nxt_op = 7'h13;
    for (int i = 0; i < 4; i++) cyc("t5_fetch_wait", 1'b0, 1'b0, MEM_F);
    cyc("t5_fetch_trap", 1'b0, 1'b0, TRAP_FTO);
    cyc("t5_fetch_trap2", 1'b1, 1'b0, TRAP_FTO);
    do_reset("t5_rst");

    for (int i = 0; i < 3; i++) cyc("t5_edge_wait", 1'b0, 1'b0, MEM_F);
    cyc("t5_edge_ready", 1'b1, 1'b0, F_RDY);
    cyc("t5_edge_decode", 1'b1, 1'b0, IDLE);
    cyc("t5_edge_exec", 1'b1, 1'b0, IDLE);
    cyc("t5_edge_wb", 1'b1, 1'b0, WB_ALU_E);

    nxt_op = 7'h03;
    nxt_fn = 4'b0010;
    cyc("t5_lw_fetch", 1'b1, 1'b0, F_RDY);
    cyc("t5_lw_decode", 1'b1, 1'b0, IDLE);
    cyc("t5_lw_exec", 1'b1, 1'b0, IDLE);
    for (int i = 0; i < 4; i++) cyc("t5_mem_wait", 1'b0, 1'b0, MEM_RD);
    cyc("t5_data_trap", 1'b0, 1'b0, TRAP_DTO);
    do_reset("t5_rst2");

    nxt_op = 7'h23;
    nxt_fn = 4'b0010;
    cyc("t6_fetch", 1'b1, 1'b0, F_RDY);
    cyc("t6_decode", 1'b1, 1'b0, IDLE);
    cyc("t6_exec", 1'b1, 1'b0, IDLE);
    cyc("t6_mem", 1'b1, 1'b0, MEM_WR);
    cyc("t6_fetch2", 1'b1, 1'b0, F_RDY);
    cyc("t6_decode2", 1'b1, 1'b0, IDLE);
    cyc("t6_exec2", 1'b1, 1'b0, IDLE);
    cyc("t6_mem_wait", 1'b0, 1'b0, MEM_WR);
    do_reset("t6_rst_mid_mem");
    cyc("t6_refetch", 1'b1, 1'b0, F_RDY);
`ifdef MULTICYCLE_CTRL_PERF_EN
    check_eq("t6_instret", instret, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
